// File: rtl/edge_capture_if.sv
// Register/pin-side bundle for edge_capture: per-channel mode, filter length,
// raw inputs, W1C strobes and mask in; filtered level, pulses, status and irq out.
interface edge_capture_if #(
  parameter int DW = 32,
  parameter int FW = 4
);
  logic [2*DW-1:0] cfg;
  logic [FW-1:0]   filt_len;
  logic [DW-1:0]   in;
  logic [DW-1:0]   clr;
  logic [DW-1:0]   mask;
  logic [DW-1:0]   level;
  logic [DW-1:0]   pulse;
  logic [DW-1:0]   status;
  logic            irq;

  modport master (
    output cfg, filt_len, in, clr, mask,
    input  level, pulse, status, irq
  );

  modport slave (
    input  cfg, filt_len, in, clr, mask,
    output level, pulse, status, irq
  );
endinterface

// File: rtl/edge_capture.sv
// Per-channel synchronizer, glitch filter, mode-gated edge pulse,
// sticky write-1-to-clear status and maskable interrupt.
module edge_capture #(
  parameter int DW   = 32,
  parameter int SYNC = 2,
  parameter int FW   = 4
) (
  input  logic          clk,
  input  logic          nreset,
  edge_capture_if.slave bus
);

  logic [DW-1:0] sync_out;

  generate
    if (SYNC == 0) begin : g_nosync
      assign sync_out = bus.in;
    end else begin : g_sync
      logic [DW-1:0] sync_q [SYNC];
      logic [DW-1:0] sync_d [SYNC];

      always_comb begin
        sync_d[0] = bus.in;
        for (int s = 1; s < SYNC; s++) begin
          sync_d[s] = sync_q[s-1];
        end
      end

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          for (int s = 0; s < SYNC; s++) begin
            sync_q[s] <= '0;
          end
        end else begin
          for (int s = 0; s < SYNC; s++) begin
            sync_q[s] <= sync_d[s];
          end
        end
      end

      assign sync_out = sync_q[SYNC-1];
    end
  endgenerate

  logic [DW-1:0] level_q, level_d;
  logic [DW-1:0] pulse_q, pulse_d;
  logic [DW-1:0] status_q, status_d;
  logic [FW-1:0] cnt_q [DW];
  logic [FW-1:0] cnt_d [DW];

  // cnt only ever climbs while below filt_len, so it cannot wrap; ">=" lets a
  // lowered filt_len take effect on the very next mismatching sample.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < DW; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != level_q[i]) begin
        if (cnt_q[i] >= bus.filt_len) begin
          level_d[i] = sync_out[i];
          pulse_d[i] = sync_out[i] ? bus.cfg[2*i] : bus.cfg[2*i+1];
        end else begin
          cnt_d[i] = FW'(cnt_q[i] + 1'b1);
        end
      end
    end
  end

  // A pulse in the same cycle as clr wins, so no edge is ever lost.
  always_comb begin
    status_d = (status_q & ~bus.clr) | pulse_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      level_q  <= '0;
      pulse_q  <= '0;
      status_q <= '0;
      for (int i = 0; i < DW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      for (int i = 0; i < DW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.level  = level_q;
  assign bus.pulse  = pulse_q;
  assign bus.status = status_q;
  assign bus.irq    = |(status_q & ~bus.mask);

endmodule
